// File: rtl/cfg_axis_switch_sequencer.sv
// Glitch-free, rate-limited 2:1 AXIS source switch driven by a cfg word.
// Select changes commit on a current-source sample boundary, then blank and dwell.
module cfg_axis_switch_sequencer #(
    parameter int SRC_ADDR         = 0,
    parameter int CFG_WIDTH        = 1024,
    parameter int CFG_SWBIT        = 0,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int EDGE_TIMEOUT     = 255
) (
    input  logic                        a_clk,
    input  logic                        a_resetn,
    input  logic [CFG_WIDTH-1:0]        cfg,
    input  logic [AXIS_TDATA_WIDTH-1:0] S1_AXIS_tdata,
    input  logic                        S1_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S2_AXIS_tdata,
    input  logic                        S2_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    output logic                        status,
    output logic                        busy,
    output logic [15:0]                 switch_count
);

    typedef enum logic [1:0] {
        ST_STEADY,
        ST_WAIT_EDGE,
        ST_BLANK,
        ST_DWELL
    } state_t;

    localparam logic [7:0] EDGE_INIT = 8'(EDGE_TIMEOUT);

    state_t                        r_state;
    logic                          r_sel;
    logic                          r_target;
    logic [7:0]                    r_edge_cnt;
    logic [7:0]                    r_blank_cnt;
    logic [15:0]                   r_dwell_cnt;
    logic [15:0]                   r_switch_count;
    logic [AXIS_TDATA_WIDTH-1:0]   r_tdata;
    logic                          r_tvalid;

    logic [31:0]                   w_word;
    logic                          w_req;
    logic [7:0]                    w_blank_len;
    logic [15:0]                   w_dwell_len;
    logic [AXIS_TDATA_WIDTH-1:0]   w_cur_tdata;
    logic                          w_cur_tvalid;
    logic                          w_commit;
    logic                          w_do_switch;
    logic                          w_unused;

    assign w_word       = cfg[SRC_ADDR*32 +: 32];
    assign w_req        = w_word[CFG_SWBIT];
    assign w_blank_len  = w_word[15:8];
    assign w_dwell_len  = w_word[31:16];
    assign w_unused     = &{1'b0, cfg, w_word};

    assign w_cur_tdata  = r_sel ? S2_AXIS_tdata  : S1_AXIS_tdata;
    assign w_cur_tvalid = r_sel ? S2_AXIS_tvalid : S1_AXIS_tvalid;

    // Withdrawal beats commit; a valid sample and timeout together still commit once.
    assign w_commit    = (r_state == ST_WAIT_EDGE) && (w_req != r_sel) &&
                         (w_cur_tvalid || (r_edge_cnt == 8'd0));
    assign w_do_switch = (w_commit && (w_blank_len == 8'd0)) ||
                         ((r_state == ST_BLANK) && (r_blank_cnt == 8'd0));

    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            r_state        <= ST_STEADY;
            r_sel          <= 1'b0;
            r_target       <= 1'b0;
            r_edge_cnt     <= 8'd0;
            r_blank_cnt    <= 8'd0;
            r_dwell_cnt    <= 16'd0;
            r_switch_count <= 16'd0;
            r_tdata        <= '0;
            r_tvalid       <= 1'b0;
        end else begin
            // Blanking drops valid but keeps the last data word on the bus.
            if (r_state == ST_BLANK) begin
                r_tvalid <= 1'b0;
            end else begin
                r_tdata  <= w_cur_tdata;
                r_tvalid <= w_cur_tvalid;
            end

            if (w_do_switch) begin
                r_sel          <= r_target;
                r_switch_count <= r_switch_count + 16'd1;
                if (w_dwell_len != 16'd0) begin
                    r_dwell_cnt <= w_dwell_len - 16'd1;
                    r_state     <= ST_DWELL;
                end else begin
                    r_state     <= ST_STEADY;
                end
            end else begin
                case (r_state)
                    ST_STEADY: begin
                        if (w_req != r_sel) begin
                            r_target   <= w_req;
                            r_edge_cnt <= EDGE_INIT;
                            r_state    <= ST_WAIT_EDGE;
                        end
                    end
                    ST_WAIT_EDGE: begin
                        if (w_req == r_sel) begin
                            r_state <= ST_STEADY;
                        end else if (w_commit) begin
                            r_blank_cnt <= w_blank_len - 8'd1;
                            r_state     <= ST_BLANK;
                        end else begin
                            r_edge_cnt <= r_edge_cnt - 8'd1;
                        end
                    end
                    ST_BLANK: begin
                        r_blank_cnt <= r_blank_cnt - 8'd1;
                    end
                    ST_DWELL: begin
                        if (r_dwell_cnt == 16'd0) begin
                            r_state <= ST_STEADY;
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt - 16'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_STEADY;
                    end
                endcase
            end
        end
    end

    assign M_AXIS_tdata  = r_tdata;
    assign M_AXIS_tvalid = r_tvalid;
    assign status        = r_sel;
    assign busy          = (r_state != ST_STEADY);
    assign switch_count  = r_switch_count;

endmodule

// File: doc/cfg_axis_switch_sequencer.md
Name: cfg_axis_switch_sequencer

Overview:
- Glitch-free, rate-limited 2:1 AXIS source switch controlled by a cfg register word.
- Sits between two 125 MHz AXIS producers and one consumer in the RPSPMC signal path.
- A select change is committed only on a sample boundary of the current source. The output is then blanked for a configurable number of cycles, and the new selection is held for a minimum dwell.
- Reports selection, busy and a switch counter for PS readback.

Parameters:
- SRC_ADDR, 0: index of the 32-bit cfg word used by this block.
- CFG_WIDTH, 1024: width of the cfg bus.
- CFG_SWBIT, 0: bit in the cfg word that carries the select request.
- AXIS_TDATA_WIDTH, 32: data width of all AXIS ports.
- EDGE_TIMEOUT, 255: maximum cycles to wait for a current-source tvalid before switching anyway (8-bit counter).

Ports:
- a_clk  in  1  system clock, 125 MHz.
- a_resetn  in  1  synchronous active-low reset.
- cfg  in  CFG_WIDTH  config bus. Fields: w = cfg[SRC_ADDR*32 +: 32]; req = w[CFG_SWBIT]; blank_len = w[15:8]; dwell_len = w[31:16].
- S1_AXIS_tdata  in  AXIS_TDATA_WIDTH  source 1 data (sel=0).
- S1_AXIS_tvalid  in  1  source 1 valid.
- S2_AXIS_tdata  in  AXIS_TDATA_WIDTH  source 2 data (sel=1).
- S2_AXIS_tvalid  in  1  source 2 valid.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  registered output data.
- M_AXIS_tvalid  out  1  registered output valid.
- status  out  1  currently committed selection (sel).
- busy  out  1  high in any state other than STEADY.
- switch_count  out  16  number of committed switches; wraps 0xFFFF -> 0.

Behaviour:
- Reset (a_resetn=0 at a rising edge):
  - Outputs: sel=0, state=STEADY, M_AXIS_tdata=0, M_AXIS_tvalid=0, busy=0, switch_count=0.
  - Internals: all counters=0.
  - Reset mid-operation aborts any pending switch; no count increment.
- Datapath:
  - When passing, M_AXIS_tdata/tvalid are S[sel] registered, with 1-cycle latency.
  - When blanking, M_AXIS_tvalid=0 and M_AXIS_tdata holds its last value.
  - No tready; no backpressure.
- STEADY:
  - Pass S[sel].
  - If req != sel: latch target=req, load edge_cnt=EDGE_TIMEOUT, go to WAIT_EDGE.
- WAIT_EDGE:
  - Pass S[sel].
  - If req==sel (request withdrawn), return to STEADY. No blank, no count.
  - Otherwise, if the current source tvalid=1 this cycle (that sample is still passed), or edge_cnt==0, commit:
    - blank_len>0: load blank_cnt=blank_len-1, go to BLANK.
    - blank_len==0: switch this cycle (see switch action).
  - Otherwise decrement edge_cnt.
  - The withdrawal check has priority over the commit.
- BLANK:
  - Output blanked. req changes are ignored (already committed).
  - blank_cnt==0: switch action. Otherwise decrement.
  - Exactly blank_len cycles with M_AXIS_tvalid=0.
- Switch action:
  - sel<=target, switch_count++.
  - dwell_len>0: load dwell_cnt=dwell_len-1, go to DWELL. dwell_len==0: go to STEADY.
- DWELL:
  - Pass S[new sel]. req is not sampled.
  - dwell_cnt==0: go to STEADY. Otherwise decrement.
  - A request pending at expiry is picked up by STEADY on the next cycle.
- Timing of the switch:
  - The first output sample from the new source appears 1 cycle after the switch action.
  - busy deasserts the cycle state enters STEADY.
- Config sampling:
  - blank_len/dwell_len are sampled only at the load points above.
  - Changing them mid-sequence has no effect on the sequence in progress.
- Simultaneous events:
  - A tvalid on the current source in the same cycle as edge_cnt reaching 0 gives a single commit.
- Arithmetic:
  - All counters are unsigned.
  - switch_count wraps modulo 2^16.

Test Plan:
- Reset then pass-through: a_resetn low 3 cycles, then S1 tvalid=1 with data 0x11,0x22,0x33 -> outputs 0,0 during reset; after reset M_AXIS_tdata 0x11,0x22,0x33 one cycle delayed; status=0, busy=0.
- Full switch: blank_len=4, dwell_len=10, S1 tvalid every 8th cycle, set req=1 ->
  - waits for the next S1 tvalid, which is output;
  - then exactly 4 cycles tvalid=0;
  - then status=1, switch_count=1, S2 data passed;
  - busy high for 10 further cycles, then low.
- Withdrawn request: req=1 for 3 cycles while S1 tvalid=0, then req=0 -> returns to STEADY, no blank cycles, switch_count=0, status=0.
- Timeout: S1 tvalid held 0, EDGE_TIMEOUT=255, blank_len=0, req=1 -> switch occurs 256 cycles after entering WAIT_EDGE; status=1, switch_count=1.
- Dwell rate limit: dwell_len=100, req toggled 1 then 0 two cycles after the first switch -> second switch not started before DWELL ends; total switch_count=2 after both sequences; no tvalid glitch outside blank windows.
- Reset mid-blank: blank_len=50, reset asserted during BLANK -> status=0, switch_count=0, M_AXIS_tvalid=0, busy=0 on the next cycle.
